// File: rtl/medfilt_pkg.sv
// Shared definitions for the median-filter pipeline: image geometry,
// pixel width, UART bit timing helper and the UART transmitter state encoding.
package medfilt_pkg;

   localparam int IMG_COLS = 512;
   localparam int IMG_ROWS = 512;
   localparam int PIX_W    = 8;

   // Transmitter states; encoding is fixed so the state can be probed directly.
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Clock cycles per UART bit (integer divide, truncating).
   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/pix_fifo.sv
// Single-clock pixel FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate occupancy counter. flush empties the FIFO
// and takes priority over any write or read in the same cycle.
module pix_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign do_wr   = wr_en && !full && !flush;
   assign do_rd   = rd_en && !empty && !flush;

   // Pointer update: flush resets both, otherwise advance on accepted accesses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/medfilt_uart_tx.sv
// UART 8N1 sink for the median-filter output stream. Pixels are buffered in a
// small FIFO and sent LSB first. The line output is registered one cycle behind
// the FSM state, so a byte's stop bit ends on the wire at the same edge that
// pix_sent counts it and busy drops.
module medfilt_uart_tx
   import medfilt_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16,
   parameter int PIX_COUNT  = IMG_COLS * IMG_ROWS
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             pix_valid,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             clear,
   output logic             uart_txd,
   output logic             busy,
   output logic             frame_done,
   output logic             overflow,
   output logic [17:0]      pix_sent
);

   localparam int              CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int              CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [17:0]     SENT_LAST    = 18'(PIX_COUNT - 1);

   tx_state_t        state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [PIX_W-1:0] shift_reg;
   logic             byte_done_p1;
   logic             skip_count;

   logic             fifo_full;
   logic             fifo_empty;
   logic [PIX_W-1:0] fifo_rd_data;
   logic             baud_last;
   logic             tx_pop;

   assign baud_last = (baud_cnt == CNT_LAST);
   // A byte is taken from the FIFO when idle, or at the last stop-bit cycle so
   // consecutive bytes run with no idle gap. clear suppresses the pop.
   assign tx_pop    = !fifo_empty && !clear &&
                      ((state == TX_IDLE) || ((state == TX_STOP) && baud_last));

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .flush   (clear),
      .wr_en   (pix_valid && !clear),
      .wr_data (pix_data),
      .rd_en   (tx_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Transmit FSM with baud/bit counters and the registered serial line.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= TX_IDLE;
         baud_cnt     <= '0;
         bit_idx      <= '0;
         uart_txd     <= 1'b1;
         byte_done_p1 <= 1'b0;
      end else begin
         byte_done_p1 <= 1'b0;
         case (state)
            TX_START: uart_txd <= 1'b0;
            TX_DATA:  uart_txd <= shift_reg[0];
            default:  uart_txd <= 1'b1;
         endcase
         case (state)
            TX_IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (tx_pop) state <= TX_START;
            end
            TX_START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= TX_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) state <= TX_STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (baud_last) begin
                  baud_cnt     <= '0;
                  byte_done_p1 <= 1'b1;
                  state        <= tx_pop ? TX_START : TX_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

   // Shift register: load on pop, shift right at each data-bit boundary.
   always_ff @(posedge CLK) begin
      if (tx_pop)                              shift_reg <= fifo_rd_data;
      else if ((state == TX_DATA) && baud_last) shift_reg <= {1'b0, shift_reg[PIX_W-1:1]};
   end

   // Status: byte/frame counting, sticky overflow and busy. A clear while a
   // byte is in flight marks that byte so its completion is not counted.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pix_sent   <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         skip_count <= 1'b0;
         busy       <= 1'b0;
      end else begin
         busy       <= !fifo_empty || (state != TX_IDLE);
         frame_done <= 1'b0;
         if (clear) begin
            pix_sent   <= '0;
            overflow   <= 1'b0;
            skip_count <= (state != TX_IDLE);
         end else begin
            if (pix_valid && fifo_full) overflow <= 1'b1;
            if (byte_done_p1) begin
               if (skip_count) begin
                  skip_count <= 1'b0;
               end else if (pix_sent == SENT_LAST) begin
                  pix_sent   <= '0;
                  frame_done <= 1'b1;
               end else begin
                  pix_sent <= pix_sent + 1'b1;
               end
            end
         end
      end
   end

endmodule
